// File: rtl/busy_bit_table_ckpt.sv
// Busy-bit table with an internal circular file of branch checkpoints.
// Optional BBT_WAKE_FORWARD_EN: same-cycle wakeups read as ready.
module busy_bit_table_ckpt #(
  parameter int NUM_PR    = 64,
  parameter int NUM_ALLOC = 2,
  parameter int NUM_WAKE  = 4,
  parameter int NUM_RD    = 4,
  parameter int NUM_CKPT  = 4,
  localparam int PA = $clog2(NUM_PR),
  localparam int CA = $clog2(NUM_CKPT)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_ALLOC-1:0]    alloc_valid,
  input  logic [NUM_ALLOC*PA-1:0] alloc_addr,
  input  logic                    stall,
  input  logic [NUM_WAKE-1:0]     wake_valid,
  input  logic [NUM_WAKE*PA-1:0]  wake_addr,
  input  logic                    ckpt_take,
  output logic [CA-1:0]           ckpt_id,
  output logic                    ckpt_full,
  input  logic                    ckpt_release,
  input  logic                    restore_valid,
  input  logic [CA-1:0]           restore_id,
  input  logic [NUM_RD*PA-1:0]    rd_addr,
  output logic [NUM_RD-1:0]       rd_busy,
  output logic [NUM_PR-1:0]       busy_vec,
  output logic [NUM_PR-1:0]       busy_next
);

  localparam logic [CA:0] ONE  = (CA+1)'(1);
  localparam logic [CA:0] FULL = (CA+1)'(NUM_CKPT);

  logic [NUM_PR-1:0] busy_q;
  logic [NUM_PR-1:0] ckpt_mem [NUM_CKPT];
  logic [CA-1:0]     head, tail;
  logic [CA:0]       count, count_nxt, rst_cnt;
  logic [NUM_PR-1:0] wake_mask, alloc_mask;
  logic              take_ok, rel_ok;

  // Decode wakeup and allocate ports into per-register masks
  always_comb begin
    wake_mask  = '0;
    alloc_mask = '0;
    for (int j = 0; j < NUM_WAKE; j++)
      if (wake_valid[j])
        wake_mask[wake_addr[j*PA +: PA]] = 1'b1;
    for (int i = 0; i < NUM_ALLOC; i++)
      if (alloc_valid[i] && !stall)
        alloc_mask[alloc_addr[i*PA +: PA]] = 1'b1;
    alloc_mask[0] = 1'b0;
  end

  // Next busy state: restore replaces the table, else alloc beats wake
  always_comb begin
    if (restore_valid)
      busy_next = ckpt_mem[restore_id] & ~wake_mask;
    else
      busy_next = (busy_q & ~wake_mask) | alloc_mask;
  end

  // Checkpoint pointer bookkeeping
  always_comb begin
    take_ok = ckpt_take && !ckpt_full && !restore_valid;
    rel_ok  = ckpt_release && (count != '0) && !restore_valid;
    rst_cnt = {1'b0, CA'(restore_id - head)};
    unique case ({take_ok, rel_ok})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  // State update: busy table, snapshot file and ring pointers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= '0;
      for (int s = 0; s < NUM_CKPT; s++)
        ckpt_mem[s] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      busy_q <= busy_next;
      for (int s = 0; s < NUM_CKPT; s++)
        if (take_ok && tail == CA'(s))
          ckpt_mem[s] <= busy_next;
        else
          ckpt_mem[s] <= ckpt_mem[s] & ~wake_mask;
      if (restore_valid) begin
        tail  <= restore_id;
        count <= rst_cnt;
      end else begin
        if (take_ok)
          tail <= tail + CA'(1);
        if (rel_ok)
          head <= head + CA'(1);
        count <= count_nxt;
      end
    end
  end

  // Operand busy reads
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
`ifdef BBT_WAKE_FORWARD_EN
      rd_busy[k] = busy_q[rd_addr[k*PA +: PA]]
                 & ~wake_mask[rd_addr[k*PA +: PA]];
`else
      rd_busy[k] = busy_q[rd_addr[k*PA +: PA]];
`endif
    end
  end

  assign busy_vec  = busy_q;
  assign ckpt_id   = tail;
  assign ckpt_full = (count == FULL);

endmodule

// File: tb/tb_busy_bit_table_ckpt.sv
// Directed self-checking bench for busy_bit_table_ckpt.
// Expected values are hand-computed per step.
module tb_busy_bit_table_ckpt;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  alloc_valid;
  logic [11:0] alloc_addr;
  logic        stall;
  logic [3:0]  wake_valid;
  logic [23:0] wake_addr;
  logic        ckpt_take;
  logic [1:0]  ckpt_id;
  logic        ckpt_full;
  logic        ckpt_release;
  logic        restore_valid;
  logic [1:0]  restore_id;
  logic [23:0] rd_addr;
  logic [3:0]  rd_busy;
  logic [63:0] busy_vec;
  logic [63:0] busy_next;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  busy_bit_table_ckpt dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .stall(stall),
    .wake_valid(wake_valid), .wake_addr(wake_addr),
    .ckpt_take(ckpt_take), .ckpt_id(ckpt_id),
    .ckpt_full(ckpt_full), .ckpt_release(ckpt_release),
    .restore_valid(restore_valid), .restore_id(restore_id),
    .rd_addr(rd_addr), .rd_busy(rd_busy),
    .busy_vec(busy_vec), .busy_next(busy_next)
  );

  function automatic logic [63:0] bv(input int a);
    return 64'd1 << a;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alloc_valid   = '0;
    alloc_addr    = '0;
    stall         = 1'b0;
    wake_valid    = '0;
    wake_addr     = '0;
    ckpt_take     = 1'b0;
    ckpt_release  = 1'b0;
    restore_valid = 1'b0;
    restore_id    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    rd_addr = '0;
    idle();
    step();
    chk("reset_busy", busy_vec, 64'd0);
    chk("reset_full", 64'(ckpt_full), 64'd0);
    chk("reset_id", 64'(ckpt_id), 64'd0);
    reset_n = 1'b1;

    // alloc PR5 / PR9 on both ports
    alloc_valid = 2'b11;
    alloc_addr  = {6'd9, 6'd5};
    step();
    chk("alloc_5_9", busy_vec, bv(5) | bv(9));

    // port 1 alone, port 0 address must be ignored
    alloc_valid = 2'b10;
    alloc_addr  = {6'd13, 6'd14};
    step();
    chk("alloc_p1_only", busy_vec, bv(5) | bv(9) | bv(13));

    // wake + alloc same reg: alloc wins
    alloc_valid = 2'b01;
    alloc_addr  = {6'd0, 6'd5};
    wake_valid  = 4'b0001;
    wake_addr   = {18'd0, 6'd5};
    step();
    chk("alloc_beats_wake", busy_vec, bv(5) | bv(9) | bv(13));

    // wake PR5 alone; alloc PR3 and PR0
    alloc_valid = 2'b11;
    alloc_addr  = {6'd0, 6'd3};
    step();
    chk("wake_and_pr0", busy_vec, bv(3) | bv(9) | bv(13));

    // stall blocks alloc PR7, wake PR3 still applies
    idle();
    stall       = 1'b1;
    alloc_valid = 2'b11;
    alloc_addr  = {6'd7, 6'd7};
    wake_valid  = 4'b0001;
    wake_addr   = {18'd0, 6'd3};
    #1;
    chk("stall_next", busy_next, bv(9) | bv(13));
    step();
    chk("stall_busy", busy_vec, bv(9) | bv(13));

    // duplicate wakes across ports
    idle();
    wake_valid = 4'b1110;
    wake_addr  = {6'd9, 6'd9, 6'd13, 6'd0};
    step();
    chk("dup_wake", busy_vec, 64'd0);

    // fill all four checkpoints
    idle();
    ckpt_take = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_id", 64'(ckpt_id), 64'(i));
      chk("fill_notfull", 64'(ckpt_full), 64'd0);
      step();
    end
    chk("full_set", 64'(ckpt_full), 64'd1);
    chk("full_id", 64'(ckpt_id), 64'd0);
    step();
    chk("take_when_full", 64'(ckpt_full), 64'd1);
    chk("tail_held", 64'(ckpt_id), 64'd0);

    // one release -> count 3
    idle();
    ckpt_release = 1'b1;
    step();
    chk("rel_notfull", 64'(ckpt_full), 64'd0);
    chk("rel_id", 64'(ckpt_id), 64'd0);

    // take + release together keep count at 3
    ckpt_take = 1'b1;
    step();
    chk("take_rel_full", 64'(ckpt_full), 64'd0);
    chk("take_rel_id", 64'(ckpt_id), 64'd1);
    idle();
    ckpt_take = 1'b1;
    step();
    chk("refill_full", 64'(ckpt_full), 64'd1);
    chk("refill_id", 64'(ckpt_id), 64'd2);

    // restore checkpoint at the restart from reset
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("reset2_id", 64'(ckpt_id), 64'd0);

    // alloc PR10 and take ckpt 0 in the same cycle
    alloc_valid = 2'b01;
    alloc_addr  = {6'd0, 6'd10};
    ckpt_take   = 1'b1;
    step();
    chk("take0_busy", busy_vec, bv(10));
    chk("take0_id", 64'(ckpt_id), 64'd1);
    idle();
    alloc_valid = 2'b01;
    alloc_addr  = {6'd0, 6'd11};
    step();
    idle();
    wake_valid = 4'b0001;
    wake_addr  = {18'd0, 6'd10};
    step();
    chk("pre_restore", busy_vec, bv(11));
    idle();
    restore_valid = 1'b1;
    restore_id    = 2'd0;
    ckpt_release  = 1'b1;
    alloc_valid   = 2'b01;
    alloc_addr    = {6'd0, 6'd12};
    #1;
    chk("restore_next", busy_next, 64'd0);
    step();
    chk("restore_busy", busy_vec, 64'd0);
    chk("restore_full", 64'(ckpt_full), 64'd0);
    chk("restore_id", 64'(ckpt_id), 64'd0);

    // restore a younger slot with a same-cycle wake
    idle();
    alloc_valid = 2'b01;
    alloc_addr  = {6'd0, 6'd15};
    ckpt_take   = 1'b1;
    step();
    alloc_addr  = {6'd0, 6'd16};
    step();
    idle();
    alloc_valid = 2'b01;
    alloc_addr  = {6'd0, 6'd17};
    step();
    chk("three_busy", busy_vec, bv(15) | bv(16) | bv(17));
    idle();
    restore_valid = 1'b1;
    restore_id    = 2'd1;
    wake_valid    = 4'b0100;
    wake_addr     = {6'd0, 6'd16, 12'd0};
    step();
    chk("restore1_busy", busy_vec, bv(15));
    chk("restore1_id", 64'(ckpt_id), 64'd1);
    idle();
    ckpt_take = 1'b1;
    step();
    step();
    chk("cnt3_notfull", 64'(ckpt_full), 64'd0);
    step();
    chk("cnt4_full", 64'(ckpt_full), 64'd1);
    chk("cnt4_id", 64'(ckpt_id), 64'd0);

    // wake forwarding on the read ports
    idle();
    alloc_valid = 2'b01;
    alloc_addr  = {6'd0, 6'd20};
    step();
    idle();
    rd_addr    = {6'd0, 6'd0, 6'd15, 6'd20};
    wake_valid = 4'b0001;
    wake_addr  = {18'd0, 6'd20};
    #1;
`ifdef BBT_WAKE_FORWARD_EN
    chk("rd_fwd", 64'(rd_busy), 64'b0010);
`else
    chk("rd_nofwd", 64'(rd_busy), 64'b0011);
`endif
    step();
    chk("rd_after_wake", 64'(rd_busy), 64'b0010);

    // reset during a restore wins
    idle();
    restore_valid = 1'b1;
    restore_id    = 2'd0;
    alloc_valid   = 2'b01;
    alloc_addr    = {6'd0, 6'd21};
    reset_n       = 1'b0;
    step();
    chk("rst_mid_busy", busy_vec, 64'd0);
    chk("rst_mid_full", 64'(ckpt_full), 64'd0);
    chk("rst_mid_id", 64'(ckpt_id), 64'd0);
    idle();
    reset_n = 1'b1;
    step();
    chk("rst_mid_hold", busy_vec, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
